dendrite_arbiter: RTL
=====================

// Module: dendrite_arbiter
//
// PURPOSE
//   Parametrised arbiter that merges fire events from NUM_SYN synapse
//   channels plus one external incoming-fire port onto a single dendrite
//   input. Grants are fair round-robin across synapses. The incoming port is
//   either strict-priority or a ring member, selected by parameter. The
//   output is registered, so the dendrite path is cut with full throughput.
//   Sits between the synapse units / host input and the dendrite unit.
//
// PARAMETERS
//   NUM_SYN      4   number of synapse channels (>=1)
//   ADDR_W       8   dendrite address width
//   CHG_W        8   input charge width; synapse charge signed, incoming unsigned
//   IN_PRIORITY  1   1: incoming port strict priority; 0: incoming is ring slot NUM_SYN
//
// PORTS
//   clk          in   1                clock
//   reset        in   1                synchronous, active-high
//   enable       in   1                0 blocks new grants
//   syn_addr     in   NUM_SYN*ADDR_W   channel i at [i*ADDR_W +: ADDR_W]
//   syn_charge   in   NUM_SYN*CHG_W    channel i at [i*CHG_W +: CHG_W], signed
//   syn_vld      in   NUM_SYN          per-channel valid
//   syn_rdy      out  NUM_SYN          per-channel ready (one-hot or zero)
//   in_addr      in   ADDR_W           incoming-fire address
//   in_charge    in   CHG_W            incoming-fire charge, unsigned
//   in_vld       in   1                incoming valid
//   in_rdy       out  1                incoming ready
//   dend_addr    out  ADDR_W           registered dendrite address
//   dend_charge  out  CHG_W+1          registered signed charge
//   dend_vld     out  1                output valid
//   dend_rdy     in   1                dendrite ready
//
// BEHAVIOUR
//   - Reset: dend_vld=0, dend_addr=0, dend_charge=0, rr_ptr=0.
//     All rdy outputs are 0 during reset.
//   - Slot free: slot_free = !dend_vld || dend_rdy.
//     Grants occur only when enable && slot_free.
//   - Grant: exactly one requester with vld=1 is granted per cycle. Its rdy=1
//     in that cycle (combinational from vld). All other rdy=0.
//     Transfer = vld && rdy. The granted payload is loaded into the output
//     register on the next edge, with dend_vld<=1. Latency is 1 cycle.
//   - No grant in a cycle where dend_rdy=1: dend_vld<=0 next cycle.
//     Output is held stable while dend_vld && !dend_rdy.
//   - Back-to-back: one transfer per cycle is sustained when dend_rdy=1 constantly.
//   - IN_PRIORITY=1: in_vld wins over all synapses, and rr_ptr is unchanged.
//     Otherwise the first valid synapse at index rr_ptr, rr_ptr+1, ...
//     (mod NUM_SYN) wins.
//   - IN_PRIORITY=0: the ring has NUM_SYN+1 slots and the incoming port is slot NUM_SYN.
//   - After a ring grant to slot k: rr_ptr <= (k+1) mod ring size.
//     rr_ptr is unchanged when there is no grant.
//   - Charge: synapse charge is sign-extended to CHG_W+1.
//     Incoming charge is zero-extended (1'b0 prepended). There is no saturation.
//   - enable=0: all rdy=0. A held output still drains on dend_rdy, then
//     dend_vld drops. rr_ptr is frozen.
//   - Reset mid-transfer: a pending output is discarded and rr_ptr returns to 0.
//     Upstream senders must hold vld (the usual valid/ready rule).
//   - Requesters must not drop vld or change payload before their transfer.
//     The arbiter does not check this.
//
// TESTING
//   1 Reset: hold reset with all vld=1. Expect dend_vld=0, all rdy=0,
//     outputs=0. Release, and the first grant goes to in (IN_PRIORITY=1).
//   2 Round robin: IN_PRIORITY=1, syn_vld=4'b1111 constant, dend_rdy=1.
//     Grant order is 0,1,2,3,0. One dend_vld per cycle, addr matches channel.
//   3 Priority vs ring: in_vld=1 with syn_vld=4'b0100. Expect in granted every
//     cycle while IN_PRIORITY=1. With IN_PRIORITY=0, the order is 2,in,2,in.
//   4 Backpressure: dend_rdy=0 for 5 cycles after one grant. Expect dend_* held
//     and all rdy=0. Raise dend_rdy, then the next grant follows, no bubble.
//   5 Charge extension: syn_charge=8'h80 gives dend_charge=9'h180 (-128).
//     in_charge=8'h80 gives 9'h080 (+128). syn 8'h7F gives 9'h07F.
//   6 Enable: deassert enable with an output pending and dend_rdy=1. Expect
//     drain next cycle, then dend_vld=0, no rdy until enable returns, and
//     rr_ptr preserved.

Source files
------------

// File: rtl/dendrite_arbiter.sv
// -----------------------------------------------------------------------------
// dendrite_arbiter
//
// Merges fire events from NUM_SYN synapse channels and one external
// incoming-fire port onto a single dendrite input. Synapses are served
// round-robin. The incoming port either pre-empts every synapse
// (IN_PRIORITY=1) or takes its turn as an extra ring slot after the synapses
// (IN_PRIORITY=0). The output is a single register stage. It accepts a new
// event in the same cycle that the dendrite drains the old one, so the
// arbiter sustains one event per cycle.
//
// Parameters
//   NUM_SYN      number of synapse channels (>=1)
//   ADDR_W       dendrite address width
//   CHG_W        input charge width (synapse signed, incoming unsigned)
//   IN_PRIORITY  1: incoming port has strict priority; 0: incoming is ring
//                slot NUM_SYN
//
// Ports
//   clk          clock
//   reset        synchronous, active-high
//   enable       0 blocks new grants; a held output still drains
//   syn_addr     packed addresses, channel i at [i*ADDR_W +: ADDR_W]
//   syn_charge   packed signed charges, channel i at [i*CHG_W +: CHG_W]
//   syn_vld      per-channel valid
//   syn_rdy      per-channel ready, one-hot or zero
//   in_addr      incoming-fire address
//   in_charge    incoming-fire charge, unsigned
//   in_vld       incoming valid
//   in_rdy       incoming ready
//   dend_addr    registered dendrite address
//   dend_charge  registered signed charge, CHG_W+1 bits
//   dend_vld     output valid
//   dend_rdy     dendrite ready
// -----------------------------------------------------------------------------
module dendrite_arbiter #(
    parameter int NUM_SYN     = 4,
    parameter int ADDR_W      = 8,
    parameter int CHG_W       = 8,
    parameter int IN_PRIORITY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_SYN*ADDR_W-1:0] syn_addr,
    input  logic [NUM_SYN*CHG_W-1:0]  syn_charge,
    input  logic [NUM_SYN-1:0]        syn_vld,
    output logic [NUM_SYN-1:0]        syn_rdy,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [CHG_W-1:0]          in_charge,
    input  logic                      in_vld,
    output logic                      in_rdy,
    output logic [ADDR_W-1:0]         dend_addr,
    output logic [CHG_W:0]            dend_charge,
    output logic                      dend_vld,
    input  logic                      dend_rdy
);

    // The ring holds only the synapses when the incoming port has priority.
    // Otherwise the incoming port is an extra slot at index NUM_SYN.
    localparam int RING  = NUM_SYN + ((IN_PRIORITY != 0) ? 0 : 1);
    localparam int PTR_W = (RING > 1) ? $clog2(RING) : 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]  rr_ptr_q,      rr_ptr_d;
    logic              dend_vld_q,    dend_vld_d;
    logic [ADDR_W-1:0] dend_addr_q,   dend_addr_d;
    logic [CHG_W:0]    dend_charge_q, dend_charge_d;

    // -------------------------------------------------------------------------
    // Request ring
    // -------------------------------------------------------------------------
    logic [RING-1:0] ring_req;

    generate
        if (IN_PRIORITY != 0) begin : g_ring_syn_only
            assign ring_req = syn_vld;
        end else begin : g_ring_with_in
            assign ring_req = {in_vld, syn_vld};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin search. This finds the first requesting slot at or after
    // rr_ptr_q, wrapping modulo RING.
    // -------------------------------------------------------------------------
    logic             ring_hit;
    logic [PTR_W-1:0] ring_win;
    logic [PTR_W-1:0] ring_next;

    // NOTE: every signal assigned in an always_comb gets a default value at the
    // top of the block. Any path that leaves a signal unassigned would infer a
    // latch.
    always_comb begin
        ring_hit = 1'b0;
        ring_win = '0;
        for (int j = 0; j < RING; j++) begin
            int idx;
            idx = int'(rr_ptr_q) + j;
            if (idx >= RING) begin
                idx = idx - RING;
            end
            if (!ring_hit && ring_req[PTR_W'(idx)]) begin
                ring_hit = 1'b1;
                ring_win = PTR_W'(idx);
            end
        end
    end

    // The pointer moves to the slot after the winner, wrapping at the ring end.
    assign ring_next = (ring_win == PTR_W'(RING - 1)) ? '0 : ring_win + 1'b1;

    // -------------------------------------------------------------------------
    // Grant decision
    // -------------------------------------------------------------------------
    logic slot_free;
    logic grant_ok;
    logic prio_in;

    // The output register can take a new event when it is empty or is being
    // drained this cycle. The reset term keeps every ready low while reset is
    // held, because reset discards any load anyway.
    assign slot_free = !dend_vld_q || dend_rdy;
    assign grant_ok  = enable && slot_free && !reset;
    assign prio_in   = (IN_PRIORITY != 0) && in_vld;

    always_comb begin
        syn_rdy  = '0;
        in_rdy   = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (grant_ok) begin
            if (prio_in) begin
                // A priority grant to the incoming port leaves the ring untouched.
                in_rdy = 1'b1;
            end else if (ring_hit) begin
                rr_ptr_d = ring_next;
                if (int'(ring_win) >= NUM_SYN) begin
                    in_rdy = 1'b1;
                end else begin
                    syn_rdy[ring_win] = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register next-state. A ready is raised only toward a requester
    // whose vld is high, so any ready bit means a transfer this cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        dend_vld_d    = dend_vld_q;
        dend_addr_d   = dend_addr_q;
        dend_charge_d = dend_charge_q;

        if (in_rdy) begin
            dend_vld_d    = 1'b1;
            dend_addr_d   = in_addr;
            // The incoming charge is unsigned, so it is zero-extended.
            dend_charge_d = {1'b0, in_charge};
        end else if (|syn_rdy) begin
            dend_vld_d = 1'b1;
            for (int i = 0; i < NUM_SYN; i++) begin
                if (syn_rdy[i]) begin
                    dend_addr_d   = syn_addr[i*ADDR_W +: ADDR_W];
                    // The synapse charge is signed, so it is sign-extended.
                    dend_charge_d = {syn_charge[i*CHG_W + CHG_W - 1],
                                     syn_charge[i*CHG_W +: CHG_W]};
                end
            end
        end else if (slot_free) begin
            // The old event drained (or there was none) and nothing replaces it.
            dend_vld_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples the values from before the edge, whatever the evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            dend_vld_q    <= 1'b0;
            dend_addr_q   <= '0;
            dend_charge_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            dend_vld_q    <= dend_vld_d;
            dend_addr_q   <= dend_addr_d;
            dend_charge_q <= dend_charge_d;
        end
    end

    assign dend_vld    = dend_vld_q;
    assign dend_addr   = dend_addr_q;
    assign dend_charge = dend_charge_q;

endmodule
